seg7_scan_mux: RTL and testbench



---
 rtl/seg7_scan_mux.sv | 114 +++++++++++
 tb/tb_seg7_scan_mux.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - multiplexed 7-segment scanner with blanking, double-buffered frames and blink
// Optional SEG7_PWM_EN: adds duty[3:0] input that dims segments during SHOW clocks.
module seg7_scan_mux #(
  parameter int DIGITS       = 4,
  parameter int SEG_W        = 7,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 50,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIGITS*SEG_W-1:0]   seg_data,
  input  logic                      data_valid,
  input  logic [DIGITS-1:0]         blink_mask,
`ifdef SEG7_PWM_EN
  input  logic [3:0]                duty,
`endif
  output logic [SEG_W-1:0]          seg,
  output logic [DIGITS-1:0]         an,
  output logic                      frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                    state, state_nxt;
  logic [CW-1:0]             slot_cnt;
  logic [IW-1:0]             idx;
  logic [BW-1:0]             blink_cnt;
  logic                      blink_on;
  logic [DIGITS*SEG_W-1:0]   shadow, active;
  logic                      slot_wrap, frame_wrap;
  logic [SEG_W-1:0]          seg_nxt;
  logic [DIGITS-1:0]         an_nxt;
`ifdef SEG7_PWM_EN
  logic [3:0]                pwm_cnt;
`endif

  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_wrap && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= BLANK;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    seg_nxt   = '0;
    an_nxt    = '0;
    case (state)
      BLANK: if (slot_cnt == BLANK_LAST) state_nxt = SHOW;
      SHOW: begin
        if (slot_wrap) state_nxt = BLANK;
        for (int k = 0; k < DIGITS; k++) begin
          if (idx == IW'(k) && (blink_on || !blink_mask[k])) begin
            an_nxt[DIGITS-1-k] = 1'b1;
            seg_nxt            = active[k*SEG_W +: SEG_W];
          end
        end
`ifdef SEG7_PWM_EN
        if (pwm_cnt >= duty) seg_nxt = '0;
`endif
      end
      default: state_nxt = BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt    <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
      shadow      <= '0;
      active      <= '0;
      seg         <= '0;
      an          <= '0;
      frame_start <= 1'b0;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
      if (slot_wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      // Active captures the pre-edge shadow, so a strobe on the boundary edge lands one frame later.
      if (frame_wrap) begin
        active <= shadow;
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
      if (data_valid) shadow <= seg_data;
      frame_start <= frame_wrap;
      seg         <= seg_nxt;
      an          <= an_nxt;
    end
  end

`ifdef SEG7_PWM_EN
  always_ff @(posedge clk) begin
    if (rst)                pwm_cnt <= '0;
    else if (state == SHOW) pwm_cnt <= pwm_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - self-checking bench for seg7_scan_mux (SEG7_PWM_EN optional)
module tb_seg7_scan_mux;
  localparam int DIGITS = 4, SEG_W = 7, SCAN_DIV = 4, BLANK_CYCLES = 1, BLINK_FRAMES = 2;
  localparam int FL = DIGITS * SCAN_DIV;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [DIGITS*SEG_W-1:0] seg_data = '0;
  logic                    data_valid = 1'b0;
  logic [DIGITS-1:0]       blink_mask = '0;
`ifdef SEG7_PWM_EN
  logic [3:0]              duty = 4'd15;
`endif
  logic [SEG_W-1:0]        seg;
  logic [DIGITS-1:0]       an;
  logic                    frame_start;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .DIGITS(DIGITS), .SEG_W(SEG_W), .SCAN_DIV(SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .seg_data(seg_data), .data_valid(data_valid),
    .blink_mask(blink_mask),
`ifdef SEG7_PWM_EN
    .duty(duty),
`endif
    .seg(seg), .an(an), .frame_start(frame_start)
  );

  typedef struct {
    logic [DIGITS-1:0] mask;
    logic [DIGITS-1:0] exp_an;
    logic              exp_fs;
  } vec_t;

  vec_t             tbl[18];
  int               checks = 0;
  int               fails  = 0;
  int               n;
  logic [SEG_W-1:0] sh_m[DIGITS];
  logic [SEG_W-1:0] act_m[DIGITS];
  int               pwm_m;

  localparam logic [DIGITS*SEG_W-1:0] PAT1 = {7'h66, 7'h4F, 7'h5B, 7'h06};
  localparam logic [DIGITS*SEG_W-1:0] PAT2 = {7'h3F, 7'h7F, 7'h71, 7'h77};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    pwm_m = 0;
    for (int k = 0; k < DIGITS; k++) begin
      sh_m[k]  = '0;
      act_m[k] = '0;
    end
  endtask

  // Outputs in cycle n+1 are the display rule applied to scan position n.
  task automatic step();
    int cnt, id, frame;
    logic [SEG_W-1:0]  es;
    logic [DIGITS-1:0] ea;
    logic              efs, blink_off;
    cnt   = n % SCAN_DIV;
    id    = (n / SCAN_DIV) % DIGITS;
    frame = n / FL;
    blink_off = ((frame / BLINK_FRAMES) % 2) == 1;
    es = '0;
    ea = '0;
    if (cnt >= BLANK_CYCLES && !(blink_off && blink_mask[id])) begin
      ea[DIGITS-1-id] = 1'b1;
      es = act_m[id];
    end
`ifdef SEG7_PWM_EN
    if (cnt >= BLANK_CYCLES) begin
      if (pwm_m >= int'(duty)) es = '0;
      pwm_m = (pwm_m + 1) % 16;
    end
`endif
    efs = ((n + 1) % FL) == 0;
    if (n % FL == FL - 1)
      for (int k = 0; k < DIGITS; k++) act_m[k] = sh_m[k];
    if (data_valid)
      for (int k = 0; k < DIGITS; k++) sh_m[k] = seg_data[k*SEG_W +: SEG_W];
    @(posedge clk);
    #1;
    n++;
    check("seg", seg, es);
    check("an", an, ea);
    check("frame_start", frame_start, efs);
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    model_reset();
    check("rst_seg", seg, 0);
    check("rst_an", an, 0);
    check("rst_fs", frame_start, 0);
    rst = 1'b0;
  endtask

  task automatic strobe(input logic [DIGITS*SEG_W-1:0] d);
    seg_data   = d;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  initial begin
    int base, lit;
    tbl = '{
      '{4'hF, 4'b0000, 1'b0}, '{4'hF, 4'b0000, 1'b0}, '{4'hF, 4'b1000, 1'b0},
      '{4'hF, 4'b1000, 1'b0}, '{4'hF, 4'b1000, 1'b0}, '{4'hF, 4'b0000, 1'b0},
      '{4'hF, 4'b0100, 1'b0}, '{4'hF, 4'b0100, 1'b0}, '{4'hF, 4'b0100, 1'b0},
      '{4'hF, 4'b0000, 1'b0}, '{4'hF, 4'b0010, 1'b0}, '{4'hF, 4'b0010, 1'b0},
      '{4'hF, 4'b0010, 1'b0}, '{4'hF, 4'b0000, 1'b0}, '{4'hF, 4'b0001, 1'b0},
      '{4'hF, 4'b0001, 1'b0}, '{4'hF, 4'b0001, 1'b1}, '{4'hF, 4'b0000, 1'b0}
    };
    model_reset();

    apply_reset(3);
    for (int i = 0; i < 18; i++) begin
      blink_mask = tbl[i].mask;
      check("tbl_an", an, tbl[i].exp_an);
      check("tbl_fs", frame_start, tbl[i].exp_fs);
      step();
    end
    blink_mask = '0;

    // Mid-frame load shows only from the next frame.
    run_to(FL + 5);
    strobe(PAT1);
    run_to(2*FL);
    check("old_seg_last_digit", seg, 7'h00);
    check("fs_frame2", frame_start, 1);
    run_to(2*FL + 2);  check("d0_seg", seg, 7'h06); check("d0_an", an, 4'b1000);
    run_to(2*FL + 6);  check("d1_seg", seg, 7'h5B); check("d1_an", an, 4'b0100);
    run_to(2*FL + 10); check("d2_seg", seg, 7'h4F); check("d2_an", an, 4'b0010);
    run_to(2*FL + 14); check("d3_seg", seg, 7'h66); check("d3_an", an, 4'b0001);

    // Load on the boundary edge is deferred by one extra frame.
    run_to(3*FL - 1);
    strobe(PAT2);
    run_to(3*FL + 2); check("bnd_old", seg, 7'h06);
    run_to(4*FL + 2); check("bnd_new", seg, 7'h77);

    // Blink digit 1: dark in frames 2-3, lit again in frame 4.
    apply_reset(1);
    blink_mask = 4'b0010;
    run_to(2);
    strobe(PAT1);
    run_to(FL + 6);    check("blk_f1_an", an, 4'b0100); check("blk_f1_seg", seg, 7'h5B);
    run_to(2*FL + 2);  check("blk_d0_an", an, 4'b1000); check("blk_d0_seg", seg, 7'h06);
    run_to(2*FL + 6);  check("blk_f2_an", an, 4'b0000); check("blk_f2_seg", seg, 7'h00);
    run_to(3*FL + 6);  check("blk_f3_an", an, 4'b0000);
    run_to(4*FL + 6);  check("blk_f4_an", an, 4'b0100); check("blk_f4_seg", seg, 7'h5B);
    blink_mask = '0;

    // Reset during SHOW of digit 2 restarts the scan at digit 0.
    run_to(5*FL + 10);
    apply_reset(1);
    run_to(2);
    check("rs_an", an, 4'b1000);
    check("rs_seg", seg, 7'h00);
    run_to(FL + 2);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      seg_data   = {$urandom, $urandom};
      data_valid = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) blink_mask = DIGITS'($urandom);
      step();
    end
    data_valid = 1'b0;
    blink_mask = '0;

`ifdef SEG7_PWM_EN
    apply_reset(1);
    duty = 4'd4;
    run_to(1);
    strobe({DIGITS{7'h7F}});
    run_to(FL);
    lit = 0;
    base = n;
    while (n < base + 4*FL) begin
      step();
      if (an != 0 && seg != 0) lit++;
    end
    check("pwm_duty4_lit", lit, 12);
    duty = 4'd0;
    lit = 0;
    base = n;
    while (n < base + 2*FL) begin
      step();
      if (an != 0) lit++;
    end
    check("pwm_duty0_scan", lit, 2*FL - 2*DIGITS*BLANK_CYCLES);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
